ppl_lane_sched: RTL and testbench

Parametrised pixel scheduler for the ray-march pipeline. It generates the per-frame pixel sequence and dispatches pixel addresses round-robin to `LANES` parallel ray-march lanes. It collects lane results in the same rotation and presents them as one in-order pixel stream to the frame-buffer writer. It replaces the single-lane pixel counter / prepare sequencer and adds multi-lane dispatch, output back-pressure and a half-resolution mode.

---
 rtl/ppl_lane_sched.sv | 193 +++++++++++++++++++
 tb/tb_ppl_lane_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppl_lane_sched.sv
// Frame pixel sequencer: dispatches raster-order pixel addresses round-robin to LANES
// ray-march lanes and re-serialises their results into one in-order output stream.
module ppl_lane_sched #(
    parameter int H_DISP   = 1280,
    parameter int V_DISP   = 720,
    parameter int LANES    = 4,
    parameter int ADDR_W   = 20,
    parameter int TEX_W    = 13,
    parameter int BLK_W    = 15,
    parameter int PREP_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     half_res,
    output logic                     busy,
    output logic                     prepare_flag,
    output logic                     frame_done,
    output logic [LANES-1:0]         disp_valid,
    input  logic [LANES-1:0]         disp_ready,
    output logic [ADDR_W-1:0]        disp_addr,
    input  logic [LANES-1:0]         res_valid,
    output logic [LANES-1:0]         res_ready,
    input  logic [LANES*TEX_W-1:0]   res_texture_addr,
    input  logic [LANES*BLK_W-1:0]   res_block_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pixel_addr,
    output logic [TEX_W-1:0]         out_texture_addr,
    output logic [BLK_W-1:0]         out_block_addr,
    output logic [1:0]               dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // valid never depends combinationally on the matching ready.
    localparam int N_FULL = H_DISP * V_DISP;
    localparam int N_HALF = (H_DISP / 2) * (V_DISP / 2);
    localparam int CNT_W  = $clog2(N_FULL + 1);
    localparam int X_W    = (H_DISP > 2) ? $clog2(H_DISP) : 1;
    localparam int PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PC_W   = (PREP_CYC > 1) ? $clog2(PREP_CYC) : 1;

    localparam logic [PTR_W-1:0]  LAST_LANE    = PTR_W'(LANES - 1);
    localparam logic [PC_W-1:0]   PREP_LAST    = PC_W'(PREP_CYC - 1);
    localparam logic [X_W-1:0]    X_LAST_FULL  = X_W'(H_DISP - 1);
    localparam logic [X_W-1:0]    X_LAST_HALF  = X_W'(H_DISP - 2);
    localparam logic [ADDR_W-1:0] ROW_INC_FULL = ADDR_W'(H_DISP);
    localparam logic [ADDR_W-1:0] ROW_INC_HALF = ADDR_W'(2 * H_DISP);
    localparam logic [CNT_W-1:0]  LAST_FULL    = CNT_W'(N_FULL - 1);
    localparam logic [CNT_W-1:0]  LAST_HALF    = CNT_W'(N_HALF - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREP = 2'd1, S_RUN = 2'd2, S_DRAIN = 2'd3} state_t;

    state_t              r_state;
    logic                r_mode;
    logic [PC_W-1:0]     r_prep_cnt;
    logic                r_frame_done;
    logic [PTR_W-1:0]    r_d_ptr, r_c_ptr;
    logic [X_W-1:0]      r_d_x, r_c_x;
    logic [ADDR_W-1:0]   r_d_row, r_c_row;
    logic [CNT_W-1:0]    r_d_cnt, r_c_cnt, r_o_cnt;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_pix;
    logic [TEX_W-1:0]    r_out_tex;
    logic [BLK_W-1:0]    r_out_blk;

    logic                w_start, w_disp_en, w_coll_en, w_d_hs, w_c_hs, w_o_hs;
    logic [X_W-1:0]      w_x_last, w_x_step, w_d_x_nxt, w_c_x_nxt;
    logic [ADDR_W-1:0]   w_row_inc, w_d_row_nxt, w_c_row_nxt;
    logic [CNT_W-1:0]    w_last;

    assign w_start   = (r_state == S_IDLE) && frame_start;
    assign w_x_last  = r_mode ? X_LAST_HALF : X_LAST_FULL;
    assign w_x_step  = r_mode ? X_W'(2) : X_W'(1);
    assign w_row_inc = r_mode ? ROW_INC_HALF : ROW_INC_FULL;
    assign w_last    = r_mode ? LAST_HALF : LAST_FULL;

    assign w_disp_en = (r_state == S_RUN);
    assign w_coll_en = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                       (r_c_cnt <= w_last) && (!r_out_valid || out_ready);
    assign w_d_hs    = w_disp_en && disp_ready[r_d_ptr];
    assign w_c_hs    = w_coll_en && res_valid[r_c_ptr];
    assign w_o_hs    = r_out_valid && out_ready;

    // Dispatch and collect walk the same raster with a row base plus x offset.
    always_comb begin
        w_d_x_nxt   = r_d_x + w_x_step;
        w_d_row_nxt = r_d_row;
        w_c_x_nxt   = r_c_x + w_x_step;
        w_c_row_nxt = r_c_row;
        if (r_d_x == w_x_last) begin
            w_d_x_nxt   = '0;
            w_d_row_nxt = r_d_row + w_row_inc;
        end
        if (r_c_x == w_x_last) begin
            w_c_x_nxt   = '0;
            w_c_row_nxt = r_c_row + w_row_inc;
        end
    end

    always_comb begin
        disp_valid = '0;
        res_ready  = '0;
        for (int i = 0; i < LANES; i++) begin
            disp_valid[i] = w_disp_en && (r_d_ptr == PTR_W'(i));
            res_ready[i]  = w_coll_en && (r_c_ptr == PTR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_prep_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_d_ptr      <= '0;
            r_d_x        <= '0;
            r_d_row      <= '0;
            r_d_cnt      <= '0;
            r_o_cnt      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: if (frame_start) begin
                    r_state    <= S_PREP;
                    r_mode     <= half_res;
                    r_prep_cnt <= '0;
                    r_d_ptr    <= '0;
                    r_d_x      <= '0;
                    r_d_row    <= '0;
                    r_d_cnt    <= '0;
                    r_o_cnt    <= '0;
                end
                S_PREP: if (r_prep_cnt == PREP_LAST) r_state <= S_RUN;
                        else r_prep_cnt <= r_prep_cnt + 1'b1;
                S_RUN: if (w_d_hs && (r_d_cnt == w_last)) r_state <= S_DRAIN;
                S_DRAIN: if (w_o_hs && (r_o_cnt == w_last)) begin
                    r_state      <= S_IDLE;
                    r_frame_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_d_hs) begin
                r_d_ptr <= (r_d_ptr == LAST_LANE) ? '0 : r_d_ptr + 1'b1;
                r_d_x   <= w_d_x_nxt;
                r_d_row <= w_d_row_nxt;
                r_d_cnt <= r_d_cnt + 1'b1;
            end
            if (w_o_hs) r_o_cnt <= r_o_cnt + 1'b1;
        end
    end

    // One-entry output register; the collect counter mirrors dispatch order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_ptr     <= '0;
            r_c_x       <= '0;
            r_c_row     <= '0;
            r_c_cnt     <= '0;
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_tex   <= '0;
            r_out_blk   <= '0;
        end else if (w_start) begin
            r_c_ptr     <= '0;
            r_c_x       <= '0;
            r_c_row     <= '0;
            r_c_cnt     <= '0;
            r_out_valid <= 1'b0;
        end else if (w_c_hs) begin
            r_out_valid <= 1'b1;
            r_out_pix   <= r_c_row + ADDR_W'(r_c_x);
            r_out_tex   <= res_texture_addr[r_c_ptr * TEX_W +: TEX_W];
            r_out_blk   <= res_block_addr[r_c_ptr * BLK_W +: BLK_W];
            r_c_ptr     <= (r_c_ptr == LAST_LANE) ? '0 : r_c_ptr + 1'b1;
            r_c_x       <= w_c_x_nxt;
            r_c_row     <= w_c_row_nxt;
            r_c_cnt     <= r_c_cnt + 1'b1;
        end else if (w_o_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign busy             = (r_state != S_IDLE);
    assign prepare_flag     = (r_state == S_PREP);
    assign frame_done       = r_frame_done;
    assign dbg_state        = r_state;
    assign disp_addr        = r_d_row + ADDR_W'(r_d_x);
    assign out_valid        = r_out_valid;
    assign out_pixel_addr   = r_out_pix;
    assign out_texture_addr = r_out_tex;
    assign out_block_addr   = r_out_blk;

endmodule

// File: tb/tb_ppl_lane_sched.sv
// Bench for ppl_lane_sched: behavioural lanes with per-lane latency, a raster-order
// frame model and a per-cycle comparison of control outputs and the output stream.
`timescale 1ns/1ps
module tb_ppl_lane_sched;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int L  = 2;
    localparam int AW = 20;
    localparam int TW = 13;
    localparam int BW = 15;
    localparam int PC = 3;
    localparam int FD = 64;

    logic clk = 1'b0;
    logic rst, frame_start, half_res;
    logic busy, prepare_flag, frame_done;
    logic [L-1:0] disp_valid, disp_ready, res_valid, res_ready;
    logic [AW-1:0] disp_addr, out_pixel_addr;
    logic [L*TW-1:0] res_texture_addr;
    logic [L*BW-1:0] res_block_addr;
    logic out_valid, out_ready;
    logic [TW-1:0] out_texture_addr;
    logic [BW-1:0] out_block_addr;
    logic [1:0] dbg_state;

    ppl_lane_sched #(
        .H_DISP(H), .V_DISP(V), .LANES(L), .ADDR_W(AW),
        .TEX_W(TW), .BLK_W(BW), .PREP_CYC(PC)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .half_res(half_res),
        .busy(busy), .prepare_flag(prepare_flag), .frame_done(frame_done),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_addr(disp_addr),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_texture_addr(res_texture_addr), .res_block_addr(res_block_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel_addr(out_pixel_addr), .out_texture_addr(out_texture_addr),
        .out_block_addr(out_block_addr), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // lane behaviour knobs
    int lat [L];
    int tex_off;
    bit bp_mode, dr_mode;
    logic [3:0] bp_pat;

    // lane FIFOs
    logic [AW-1:0] lf_addr [L][FD];
    int lf_due [L][FD];
    int lf_wr [L];
    int lf_rd [L];

    // handshakes seen before the coming edge
    logic [L-1:0] snap_d_hs, snap_c_hs;
    logic [AW-1:0] snap_d_addr;

    // frame model and scoreboard
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_pix;
    int m_addr [H*V];
    int m_n, m_dcnt, m_ccnt, m_ocnt, m_since;
    bit m_in, m_done, m_done_nx, m_acc;
    logic [L-1:0] exp_dv, exp_rr;
    logic prev_stall;
    logic [AW-1:0] prev_pix;
    logic [TW-1:0] prev_tex;
    logic [BW-1:0] prev_blk;
    int f_outs, f_prep, f_start_cyc, f_first_disp, f_lane1_wait, f_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- lane drivers ----------------
    initial begin
        res_valid = '0;
        res_texture_addr = '0;
        res_block_addr = '0;
        disp_ready = '1;
        out_ready = 1'b1;
        for (int i = 0; i < L; i++) begin
            lf_wr[i] = 0;
            lf_rd[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < L; i++) begin
                if (rst) begin
                    lf_wr[i] = 0;
                    lf_rd[i] = 0;
                end else begin
                    if (snap_c_hs[i]) lf_rd[i]++;
                    if (snap_d_hs[i]) begin
                        lf_addr[i][lf_wr[i] % FD] = snap_d_addr;
                        lf_due[i][lf_wr[i] % FD] = cyc + lat[i] - 1;
                        lf_wr[i]++;
                    end
                end
                if (lf_rd[i] != lf_wr[i] && lf_due[i][lf_rd[i] % FD] <= cyc) begin
                    res_valid[i] = 1'b1;
                    res_texture_addr[i*TW +: TW] = TW'(lf_addr[i][lf_rd[i] % FD] + tex_off);
                    res_block_addr[i*BW +: BW] = BW'(i * 1000 + lf_addr[i][lf_rd[i] % FD]);
                end else begin
                    res_valid[i] = 1'b0;
                    res_texture_addr[i*TW +: TW] = '0;
                    res_block_addr[i*BW +: BW] = '0;
                end
            end
            out_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
            disp_ready = (dr_mode && (cyc % 3 == 0)) ? 2'b01 : 2'b11;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_prepare_flag", prepare_flag, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_disp_valid", disp_valid, 0);
            chk("rst_res_ready", res_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_disp_addr", disp_addr, 0);
            chk("rst_out_pixel_addr", out_pixel_addr, 0);
            chk("rst_out_texture_addr", out_texture_addr, 0);
            chk("rst_out_block_addr", out_block_addr, 0);
            chk("rst_state", dbg_state, 0);
            m_in = 0; m_done = 0; m_since = 0;
            m_dcnt = 0; m_ccnt = 0; m_ocnt = 0; m_n = 0;
            exp_q.delete();
            prev_stall = 1'b0;
            snap_d_hs = '0; snap_c_hs = '0; snap_d_addr = '0;
        end else begin
            chk("prepare_flag", prepare_flag, (m_in && m_since >= 1 && m_since <= PC));
            chk("busy", busy, m_in);
            chk("frame_done", frame_done, m_done);
            exp_dv = '0;
            if (m_in && m_since > PC && m_dcnt < m_n) exp_dv[m_dcnt % L] = 1'b1;
            chk("disp_valid", disp_valid, exp_dv);
            if (exp_dv != 0) chk("disp_addr", disp_addr, m_addr[m_dcnt]);
            exp_rr = '0;
            if (m_in && m_since > PC && m_ccnt < m_n && (!out_valid || out_ready))
                exp_rr[m_ccnt % L] = 1'b1;
            chk("res_ready", res_ready, exp_rr);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_pixel", out_pixel_addr, prev_pix);
                chk("hold_texture", out_texture_addr, prev_tex);
                chk("hold_block", out_block_addr, prev_blk);
            end
            m_done_nx = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_output", exp_q.size(), 1);
                end else begin
                    exp_pix = exp_q.pop_front();
                    chk("out_pixel_addr", out_pixel_addr, exp_pix);
                    chk("out_texture_addr", out_texture_addr, TW'(exp_pix + tex_off));
                    chk("out_block_addr", out_block_addr, BW'((m_ocnt % L) * 1000 + exp_pix));
                end
                m_ocnt++;
                f_outs++;
                if (m_ocnt == m_n) m_done_nx = 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_pix = out_pixel_addr;
            prev_tex = out_texture_addr;
            prev_blk = out_block_addr;
            if (res_valid[1] && !res_ready[1]) f_lane1_wait++;
            if (out_valid && !out_ready) f_stalls++;
            if (prepare_flag) f_prep++;
            if (disp_valid != 0 && f_first_disp < 0) f_first_disp = cyc - f_start_cyc;
            if ((disp_valid & disp_ready) != 0) m_dcnt++;
            if ((res_valid & res_ready) != 0) m_ccnt++;
            snap_d_hs = disp_valid & disp_ready;
            snap_c_hs = res_valid & res_ready;
            snap_d_addr = disp_addr;

            m_acc = frame_start && !m_in;
            m_done = 0;
            if (m_in) m_since++;
            if (m_done_nx) begin
                m_done = 1;
                m_in = 0;
            end
            if (m_acc) begin
                m_in = 1; m_since = 1;
                m_dcnt = 0; m_ccnt = 0; m_ocnt = 0; m_n = 0;
                exp_q.delete();
                for (int y = 0; y < V; y += (half_res ? 2 : 1))
                    for (int x = 0; x < H; x += (half_res ? 2 : 1)) begin
                        m_addr[m_n] = y * H + x;
                        exp_q.push_back(AW'(y * H + x));
                        m_n++;
                    end
                f_outs = 0; f_prep = 0; f_start_cyc = cyc; f_first_disp = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input string tag);
        int n = 0;
        while (!frame_done && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_frame_done_seen"}, frame_done, 1);
    endtask

    task automatic run_frame(input bit half, input int exp_n, input string tag);
        @(posedge clk); #2;
        frame_start = 1'b1;
        half_res = half;
        @(posedge clk); #2;
        frame_start = 1'b0;
        half_res = 1'b0;
        wait_done(tag);
        chk({tag, "_output_count"}, f_outs, exp_n);
        chk({tag, "_prepare_cycles"}, f_prep, PC);
        chk({tag, "_first_dispatch_delay"}, f_first_disp, PC + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hl [8];
        int n;
        hl = '{0, 2, 4, 6, 16, 18, 20, 22};
        rst = 1'b0; frame_start = 1'b0; half_res = 1'b0;
        bp_mode = 0; dr_mode = 0; bp_pat = 4'b1001; tex_off = 0;
        lat[0] = 2; lat[1] = 2;
        f_first_disp = -1; f_lane1_wait = 0; f_stalls = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // full resolution, all lanes ready
        run_frame(1'b0, 32, "full");
        chk("full_model_last_addr", m_addr[31], 31);

        // half resolution
        run_frame(1'b1, 8, "half");
        for (int k = 0; k < 8; k++) chk("half_model_addr", m_addr[k], hl[k]);

        // unequal lane latency
        lat[0] = 5; lat[1] = 1; tex_off = 100; f_lane1_wait = 0;
        run_frame(1'b0, 32, "unequal");
        chk("unequal_lane1_waited", (f_lane1_wait > 0), 1);

        // output back-pressure plus a periodically stalled lane 1
        lat[0] = 2; lat[1] = 2; tex_off = 0; bp_mode = 1; dr_mode = 1; f_stalls = 0;
        run_frame(1'b0, 32, "backpressure");
        chk("backpressure_stalls_seen", (f_stalls > 0), 1);
        bp_mode = 0; dr_mode = 0;

        // ignored start mid-run, then reset abort and restart
        @(posedge clk); #2;
        frame_start = 1'b1;
        @(posedge clk); #2;
        frame_start = 1'b0;
        n = 0;
        while (m_dcnt < 6 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        chk("abort_reached_run", (m_dcnt >= 6), 1);
        frame_start = 1'b1;
        @(posedge clk); #2;
        frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        run_frame(1'b0, 32, "restart");

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
